// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU encodings for the fetch stage
package cpu_pkg;

  typedef enum logic {
    FETCH_RUN    = 1'b0,
    FETCH_HALTED = 1'b1
  } fetch_state_t;

  localparam logic [31:0] INS_HALT_BUBBLE = 32'h0000_000c;
  localparam logic [31:0] NOP             = 32'h0000_0000;

  typedef enum logic [2:0] {
    PC_SEQ,
    PC_BR,
    PC_JR,
    PC_JMP,
    PC_HOLD
  } pc_sel_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - instruction-memory read port between fetch and imem
interface if_fetch_stage_if #(
  parameter int IMEM_AW = 10
);
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_data;

  modport master (output imem_addr, input imem_data);
  modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/if_next_pc.sv
// rtl/if_next_pc.sv - next-PC priority select and target alignment
module if_next_pc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        halted,
  input  logic        halt_req,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  output logic [31:0] next_pc,
  output pc_sel_t     pc_sel
);

  // EX branch beats ID redirects: it belongs to the older instruction
  always_comb begin
    pc_sel = PC_SEQ;
    if (br_taken)                        pc_sel = PC_BR;
    else if (jr)                         pc_sel = PC_JR;
    else if (jmp)                        pc_sel = PC_JMP;
    else if (halted || halt_req || stall) pc_sel = PC_HOLD;
  end

  always_comb begin
    next_pc = pc + 32'd4;
    case (pc_sel)
      PC_BR:   next_pc = word_align(br_target);
      PC_JR:   next_pc = word_align(jr_target);
      PC_JMP:  next_pc = word_align(jmp_target);
      PC_HOLD: next_pc = pc;
      default: next_pc = pc + 32'd4;
    endcase
  end

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - PC register, halt/resume FSM and fetch counter
module if_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10,
  parameter int          CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 br_taken,
  input  logic [31:0]          br_target,
  input  logic                 jmp,
  input  logic [31:0]          jmp_target,
  input  logic                 jr,
  input  logic [31:0]          jr_target,
  input  logic                 halt_req,
  input  logic                 go,
  if_fetch_stage_if.master     imem,
  output logic [31:0]          ins_o,
  output logic [31:0]          pc_o,
  output logic                 flush_o,
  output logic                 halted_o,
  output logic [CNT_W-1:0]     fetch_cnt
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, next_pc;
  pc_sel_t      pc_sel;
  logic         redirect;

  if_next_pc u_next_pc (
    .pc         (pc),
    .halted     (state == FETCH_HALTED),
    .halt_req   (halt_req),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jr         (jr),
    .jr_target  (jr_target),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .next_pc    (next_pc),
    .pc_sel     (pc_sel)
  );

  assign redirect       = br_taken | jr | jmp;
  assign flush_o        = redirect;
  assign halted_o       = (state == FETCH_HALTED);
  assign imem.imem_addr = pc[IMEM_AW+1:2];
  assign pc_o           = pc + 32'd4;
  assign ins_o          = (state == FETCH_HALTED) ? INS_HALT_BUBBLE : imem.imem_data;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH_RUN;
    else     state <= state_nxt;
  end

  // A redirect while halted still moves the PC (see next-PC mux) but keeps the state
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH_RUN:    if (halt_req && !redirect) state_nxt = FETCH_HALTED;
      FETCH_HALTED: if (go)                    state_nxt = FETCH_RUN;
      default:      state_nxt = FETCH_RUN;
    endcase
  end

  // PC_SEQ in RUN means no stall, no halt request and no redirect this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      fetch_cnt <= '0;
    end else begin
      pc <= next_pc;
      if (state == FETCH_RUN && pc_sel == PC_SEQ)
        fetch_cnt <= fetch_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - scoreboard bench for if_fetch_stage
module tb_if_fetch_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, br_taken, jmp, jr, halt_req, go;
  logic [31:0] br_target, jmp_target, jr_target;
  logic [31:0] ins_o, pc_o, fetch_cnt;
  logic        flush_o, halted_o;

  always #5 clk = ~clk;

  if_fetch_stage_if #(.IMEM_AW(10)) bus ();
  assign bus.imem_data = {22'b0, bus.imem_addr};

  if_fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(10), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .jr         (jr),
    .jr_target  (jr_target),
    .halt_req   (halt_req),
    .go         (go),
    .imem       (bus.master),
    .ins_o      (ins_o),
    .pc_o       (pc_o),
    .flush_o    (flush_o),
    .halted_o   (halted_o),
    .fetch_cnt  (fetch_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic        halted;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_pc = 32'h0;
  logic        m_halted = 1'b0;
  logic [31:0] m_cnt = 32'h0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // One clock: drive inputs, check flush, push model result, pop and compare after the edge
  task automatic step(input logic r, input logic st, input logic br, input logic [31:0] brt,
                      input logic j, input logic [31:0] jt, input logic rr, input logic [31:0] rt,
                      input logic h, input logic g);
    logic        redir, nh;
    logic [31:0] tgt;
    exp_t        e;
    @(negedge clk);
    rst = r; stall = st; br_taken = br; br_target = brt; jmp = j; jmp_target = jt;
    jr = rr; jr_target = rt; halt_req = h; go = g;
    #1;
    redir = br | j | rr;
    check_val("flush", {31'b0, flush_o}, {31'b0, redir});
    tgt = br ? brt : (rr ? rt : jt);
    tgt[1:0] = 2'b00;
    if (r) begin
      m_pc = 32'h0; m_halted = 1'b0; m_cnt = 32'h0;
    end else begin
      if (!m_halted && !st && !h && !redir) m_cnt = m_cnt + 32'd1;
      nh = m_halted ? !g : (h && !redir);
      if (redir) m_pc = tgt;
      else if (!(m_halted || h || st)) m_pc = m_pc + 32'd4;
      m_halted = nh;
    end
    sb.push_back('{pc: m_pc, halted: m_halted, cnt: m_cnt});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_val("pc_o", pc_o, e.pc + 32'd4);
    check_val("imem_addr", 32'(bus.imem_addr), {22'b0, e.pc[11:2]});
    check_val("halted_o", {31'b0, halted_o}, {31'b0, e.halted});
    check_val("fetch_cnt", fetch_cnt, e.cnt);
    check_val("ins_o", ins_o, e.halted ? 32'h0000_000c : {22'b0, e.pc[11:2]});
  endtask

  task automatic free(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; jmp = 1'b0; jr = 1'b0;
    halt_req = 1'b0; go = 1'b0; br_target = '0; jmp_target = '0; jr_target = '0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_val("rst_pc_o", pc_o, 32'h4);
    free(4);
    check_val("s1_cnt", fetch_cnt, 32'd4);
    check_val("s1_addr", 32'(bus.imem_addr), 32'd4);

    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    check_val("s2_hold", pc_o, 32'h14);
    check_val("s2_cnt", fetch_cnt, 32'd4);
    free(1);
    check_val("s2_resume", pc_o, 32'h18);

    free(3);
    check_val("s3_at20", pc_o, 32'h24);
    step(0, 1, 1, 32'h100, 1, 32'h200, 0, 0, 0, 0);
    check_val("s3_br", pc_o, 32'h104);

    step(0, 0, 0, 0, 0, 0, 1, 32'h43, 0, 0);
    check_val("s4_jr", pc_o, 32'h44);

    step(0, 0, 0, 0, 1, 32'h30, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    check_val("s5_halted", {31'b0, halted_o}, 32'd1);
    check_val("s5_bubble", ins_o, 32'h0000_000c);
    for (int i = 0; i < 10; i++)
      step(0, 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)), 0);
    check_val("s5_held", pc_o, 32'h34);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check_val("s5_resume_addr", 32'(bus.imem_addr), 32'h0C);
    free(2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    check_val("halt_go_run", {31'b0, halted_o}, 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 32'h81, 0, 0, 0, 0, 0, 0);
    check_val("halt_redirect", pc_o, 32'h84);
    step(0, 0, 0, 0, 1, 32'h30, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    check_val("s6_pc", pc_o, 32'h4);
    check_val("s6_cnt", fetch_cnt, 32'd0);

    step(0, 0, 0, 0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0);
    free(1);
    check_val("wrap", pc_o, 32'h4);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 9) == 0, $urandom,
           $urandom_range(0, 9) == 0, $urandom,
           $urandom_range(0, 11) == 0, $urandom,
           $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
